// File: rtl/cpu_mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath.
// master = controller side, slave = datapath side.
interface cpu_mc_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ZF;
  logic       OF;

  logic       PC_Write;
  logic [1:0] PC_s;
  logic       IR_Write;
  logic       Mem_Write;
  logic       Reg_Write;
  logic       ALU_srcA;
  logic [1:0] ALU_srcB;
  logic [2:0] ALU_OP;
  logic       imm_s;
  logic       rd_s;
  logic       w_data_s;
  logic       illegal;
  logic       ov_trap;
  logic [3:0] state;

  modport master (
    input  run, opcode, funct, ZF, OF,
    output PC_Write, PC_s, IR_Write, Mem_Write, Reg_Write, ALU_srcA, ALU_srcB,
           ALU_OP, imm_s, rd_s, w_data_s, illegal, ov_trap, state
  );

  modport slave (
    output run, opcode, funct, ZF, OF,
    input  PC_Write, PC_s, IR_Write, Mem_Write, Reg_Write, ALU_srcA, ALU_srcB,
           ALU_OP, imm_s, rd_s, w_data_s, illegal, ov_trap, state
  );
endinterface

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle CPU control unit: Moore FSM sequencing IF/ID/EX/MEM/WB and
// driving every datapath enable and mux select.
module cpu_mc_ctrl (
  input  logic          clk,
  input  logic          rst,
  cpu_mc_ctrl_if.master bus
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OPC_R    = 6'b000000;
  localparam logic [OP_W-1:0] OPC_J    = 6'b000010;
  localparam logic [OP_W-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OPC_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OPC_SLTI = 6'b001010;
  localparam logic [OP_W-1:0] OPC_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OPC_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OPC_XORI = 6'b001110;
  localparam logic [OP_W-1:0] OPC_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OPC_SW   = 6'b101011;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR = 6'b100110;
  localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b010;
  localparam logic [ALU_W-1:0] ALU_NOR = 3'b011;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b101;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b110;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_WB_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_LW    = 4'd8,
    S_MEM_WR   = 4'd9,
    S_EX_BR    = 4'd10,
    S_EX_J     = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   of_q, of_d;

  logic             pc_write, ir_write, mem_write, reg_write;
  logic [1:0]       pc_s, alu_srcb;
  logic             alu_srca, imm_s, rd_s, w_data_s, illegal, ov_trap;
  logic [ALU_W-1:0] alu_op;

  logic             funct_ok, funct_addsub, opc_ialu;
  logic [ALU_W-1:0] alu_r, alu_i;

  // R-type funct decode: legality and ALU operation
  always_comb begin
    funct_ok = 1'b1;
    alu_r    = ALU_ADD;
    case (bus.funct)
      FN_ADD:  alu_r = ALU_ADD;
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_XOR:  alu_r = ALU_XOR;
      FN_NOR:  alu_r = ALU_NOR;
      FN_SLT:  alu_r = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign funct_addsub = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);

  // I-type ALU opcode decode
  always_comb begin
    opc_ialu = 1'b1;
    alu_i    = ALU_ADD;
    case (bus.opcode)
      OPC_ADDI: alu_i = ALU_ADD;
      OPC_SLTI: alu_i = ALU_SLT;
      OPC_ANDI: alu_i = ALU_AND;
      OPC_ORI:  alu_i = ALU_OR;
      OPC_XORI: alu_i = ALU_XOR;
      default:  opc_ialu = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      of_q    <= of_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    of_d      = of_q;
    pc_write  = 1'b0;
    pc_s      = 2'b00;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_srca  = 1'b0;
    alu_srcb  = 2'b00;
    alu_op    = ALU_AND;
    imm_s     = 1'b0;
    rd_s      = 1'b0;
    w_data_s  = 1'b0;
    illegal   = 1'b0;
    ov_trap   = 1'b0;

    case (state_q)
      S_IF: begin
        if (bus.run) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          alu_srcb = 2'b01;
          alu_op   = ALU_ADD;
          state_d  = S_ID;
        end
      end

      // Branch target PC + (imm<<2) is precomputed into ALU_Out here
      S_ID: begin
        alu_srcb = 2'b11;
        alu_op   = ALU_ADD;
        if (bus.opcode == OPC_R) begin
          if (funct_ok) begin
            state_d = S_EX_R;
          end else begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        end else if (opc_ialu) begin
          state_d = S_EX_I;
        end else if ((bus.opcode == OPC_LW) || (bus.opcode == OPC_SW)) begin
          state_d = S_MEM_ADDR;
        end else if ((bus.opcode == OPC_BEQ) || (bus.opcode == OPC_BNE)) begin
          state_d = S_EX_BR;
        end else if (bus.opcode == OPC_J) begin
          state_d = S_EX_J;
        end else begin
          illegal = 1'b1;
          state_d = S_IF;
        end
      end

      S_EX_R: begin
        alu_srca = 1'b1;
        alu_op   = alu_r;
        of_d     = bus.OF & funct_addsub;
        state_d  = S_WB_R;
      end

      S_WB_R: begin
        reg_write = ~of_q;
        ov_trap   = of_q;
        rd_s      = 1'b1;
        state_d   = S_IF;
      end

      S_EX_I: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        alu_op   = alu_i;
        imm_s    = (bus.opcode == OPC_ANDI) || (bus.opcode == OPC_ORI) ||
                   (bus.opcode == OPC_XORI);
        of_d     = bus.OF & (bus.opcode == OPC_ADDI);
        state_d  = S_WB_I;
      end

      S_WB_I: begin
        reg_write = ~of_q;
        ov_trap   = of_q;
        state_d   = S_IF;
      end

      S_MEM_ADDR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        alu_op   = ALU_ADD;
        state_d  = (bus.opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: state_d = S_WB_LW;

      // Loads are never suppressed by overflow
      S_WB_LW: begin
        reg_write = 1'b1;
        w_data_s  = 1'b1;
        state_d   = S_IF;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        state_d   = S_IF;
      end

      S_EX_BR: begin
        alu_srca = 1'b1;
        alu_op   = ALU_SUB;
        pc_s     = 2'b01;
        pc_write = (bus.opcode == OPC_BEQ) ? bus.ZF : ~bus.ZF;
        state_d  = S_IF;
      end

      S_EX_J: begin
        pc_write = 1'b1;
        pc_s     = 2'b10;
        state_d  = S_IF;
      end

      default: state_d = S_IF;
    endcase

    if (state_d == S_IF) of_d = 1'b0;
  end

  assign bus.PC_Write  = pc_write;
  assign bus.PC_s      = pc_s;
  assign bus.IR_Write  = ir_write;
  assign bus.Mem_Write = mem_write;
  assign bus.Reg_Write = reg_write;
  assign bus.ALU_srcA  = alu_srca;
  assign bus.ALU_srcB  = alu_srcb;
  assign bus.ALU_OP    = alu_op;
  assign bus.imm_s     = imm_s;
  assign bus.rd_s      = rd_s;
  assign bus.w_data_s  = w_data_s;
  assign bus.illegal   = illegal;
  assign bus.ov_trap   = ov_trap;
  assign bus.state     = state_q;

endmodule

// File: doc/cpu_mc_ctrl.md
# cpu_mc_ctrl

Multi-cycle control unit for the CPU datapath. It sequences instruction fetch, decode, execute, memory and write-back as a Moore FSM. It drives every datapath enable and mux select, and uses the ALU flags ZF/OF for branch resolution and overflow suppression. It sits beside the register file, ALU, IR/MDR/ALU_Out registers and the instruction/data memories inside CPU.

## Interface
Parameters:
- none (encodings below are fixed)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  fetch enable; low holds the FSM in IF without fetching
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- ZF  in  1  ALU zero flag, combinational from the current ALU_OP/operands
- OF  in  1  ALU signed-overflow flag, combinational
- PC_Write  out  1  PC load enable
- PC_s  out  2  PC source: 00 ALU result, 01 ALU_Out register, 10 jump address {PC[31:28],IR[25:0],2'b00}
- IR_Write  out  1  IR load enable
- Mem_Write  out  1  data memory write
- Reg_Write  out  1  register file write
- ALU_srcA  out  1  0 PC, 1 register A
- ALU_srcB  out  2  00 register B, 01 constant 4, 10 extended imm, 11 extended imm<<2
- ALU_OP  out  3  000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt
- imm_s  out  1  0 sign-extend, 1 zero-extend
- rd_s  out  1  write register: 0 rt, 1 rd
- w_data_s  out  1  write data: 0 ALU_Out, 1 MDR
- illegal  out  1  one-cycle pulse on undecodable instruction
- ov_trap  out  1  one-cycle pulse when a write-back is suppressed by overflow
- state  out  4  current state, for LED/debug

## Operation
- State codes: IF=0, ID=1, EX_R=2, WB_R=3, EX_I=4, WB_I=5, MEM_ADDR=6, MEM_RD=7, WB_LW=8, MEM_WR=9, EX_BR=10, EX_J=11. Codes 12–15 go to IF on the next edge.
- Supported opcodes:
  - R-type 000000, j 000010, beq 000100, bne 000101
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110
  - lw 100011, sw 101011
- Supported R-type funct values: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010.
- IF:
  - run=1: IR_Write=1, PC_Write=1, PC_s=00, srcA=0, srcB=01, ALU_OP=add; go to ID.
  - run=0: all enables 0; stay in IF.
- ID: srcA=0, srcB=11, imm_s=0, ALU_OP=add, which precomputes the branch target into ALU_Out. Dispatch on opcode:
  - R-type → EX_R; I-ALU → EX_I; lw/sw → MEM_ADDR; beq/bne → EX_BR; j → EX_J.
  - Anything else, or R-type with an unsupported funct: illegal=1 for this cycle, next state IF.
- EX_R: srcA=1, srcB=00, ALU_OP from funct. The of_flag register captures OF & (funct is add or sub).
- EX_I: srcA=1, srcB=10, ALU_OP add/slt/and/or/xor. imm_s=1 for andi/ori/xori, 0 otherwise. of_flag captures OF & (opcode is addi).
- WB_R / WB_I: Reg_Write = ~of_flag, ov_trap = of_flag, rd_s = 1 (WB_R) or 0 (WB_I), w_data_s=0; go to IF.
- MEM_ADDR: srcA=1, srcB=10, imm_s=0, ALU_OP=add; go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD → WB_LW. WB_LW: Reg_Write=1, rd_s=0, w_data_s=1 (never suppressed).
- MEM_WR: Mem_Write=1; go to IF.
- EX_BR: srcA=1, srcB=00, ALU_OP=sub, PC_s=01. PC_Write = ZF for beq, ~ZF for bne. Go to IF.
- EX_J: PC_Write=1, PC_s=10; go to IF.
- Every output not listed for a state is 0 in that state.
- of_flag is cleared on entry to IF.

## Timing
- Outputs are Moore, decoded from the registered state. Exceptions, which are same-cycle combinational: PC_Write in EX_BR (depends on ZF), and illegal in ID (depends on opcode/funct).
- Cycle counts from IF entry: R / I-ALU / sw 4, lw 5, beq/bne/j 3, illegal 2.
- rst low at any time: state=IF and of_flag=0 immediately. All outputs 0, except state=0 and the IF combinational values gated by run. Release is synchronous to the next clk edge.
- run falling mid-instruction does not stall; the instruction completes and the FSM then holds in IF.

## Test plan
- Reset: rst=0 mid-EX_R → state=0, Reg_Write=0 with no clock edge; release with run=1 → IR_Write=PC_Write=1 on the first cycle.
- add $3,$1,$2 with OF=0: states 0,1,2,3 → WB_R has Reg_Write=1, rd_s=1, ALU_OP=100 in EX_R. Repeat with OF=1 in EX_R → Reg_Write=0, ov_trap=1.
- lw: 5 cycles 0,1,6,7,8 → WB_LW has w_data_s=1, rd_s=0. sw: 0,1,6,9 with Mem_Write=1 only in state 9.
- beq with ZF=1 → PC_Write=1, PC_s=01 in state 10. bne with ZF=1 → PC_Write=0. Both return to 0.
- Illegal opcode 111111 and funct 000000 in R-type → illegal=1 in ID, next state 0, no write enables asserted.
- run=0 → state stays 0 for 10 cycles, IR_Write=PC_Write=0. ori with imm 0x8000 → imm_s=1 in EX_I.
